user_obi_copy_mgr: RTL and testbench
====================================

Name: user_obi_copy_mgr

Overview:
- User-domain OBI manager that copies a block of 32-bit words from a source address to a destination address over the user manager port.
- Complements the existing user-domain subordinates (Counter, Conv1d) by initiating traffic rather than responding to it. Typical use is streaming sample buffers into or out of Conv1d without core involvement.
- Configuration arrives on a flat start/address/length port group, driven by a register-interface wrapper.
- Keeps one transaction outstanding at a time; each word is one read followed by one write.

Parameters:
- AddrWidth, 32, OBI address width
- DataWidth, 32, OBI data width; fixed word size is 4 bytes
- LenWidth, 16, width of the word-count field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- src_addr_i  in  AddrWidth  source byte address; bits [1:0] ignored
- dst_addr_i  in  AddrWidth  destination byte address; bits [1:0] ignored
- len_i  in  LenWidth  number of words to copy
- busy_o  out  1  high from the cycle after start is accepted until the cycle DONE/ERR is left
- done_o  out  1  one-cycle pulse on completion or abort
- error_o  out  1  sticky error flag; cleared on the next accepted start
- words_done_o  out  LenWidth  count of words fully written
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  OBI address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  OBI byte enable
- obi_wdata_o  out  DataWidth  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  DataWidth  OBI read data
- obi_err_i  in  1  OBI response error

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address, count and data registers 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE, start_i=1 and len_i!=0:
  - latch src/dst with bits [1:0] forced to 0, latch len;
  - clear error_o and words_done_o;
  - next state RD_REQ.
- IDLE, start_i=1 and len_i==0:
  - clear error_o and words_done_o;
  - go to FIN; no bus traffic.
- start_i is ignored outside IDLE.
- RD_REQ:
  - obi_req_o=1, we=0, be=4'hF, addr=current src;
  - on gnt go to RD_WAIT.
- RD_WAIT:
  - req=0;
  - on rvalid with err=0: capture rdata into the data register, go to WR_REQ;
  - on rvalid with err=1: set error_o, go to FIN.
- WR_REQ:
  - req=1, we=1, be=4'hF, addr=current dst, wdata=data register;
  - on gnt go to WR_WAIT.
- WR_WAIT:
  - on rvalid with err=1: set error_o, go to FIN;
  - on rvalid with err=0:
    - words_done++, src+=4, dst+=4, remaining--;
    - if remaining reaches 0 go to FIN, else go to RD_REQ.
- FIN: done_o=1 for exactly this one cycle, then IDLE.
- OBI rules:
  - While obi_req_o=1 and gnt=0, addr, we, be and wdata hold stable.
  - rvalid is never expected in the same cycle as its gnt.
  - rvalid in IDLE or any *_REQ state is ignored.
  - Requests are never withdrawn before gnt except by reset.
- Throughput: minimum 4 cycles per word (gnt same cycle as req, rvalid the next cycle).
  - Latency from start to done pulse for len=1 with zero-wait bus is 6 cycles.
- Address arithmetic: src and dst are AddrWidth-bit modular; crossing 0xFFFF_FFFC wraps to 0 silently.
- Reset mid-operation:
  - next cycle req=0 and the FSM returns to IDLE;
  - an in-flight rvalid arriving after reset is ignored;
  - no done pulse is produced.
- error_o is set in the same cycle as the FSM enters FIN; words_done_o reflects only fully written words.

Decomposition:
- user_pkg gains:
  - the manager count constant NumUserDomainManagers=1;
  - enum user_mgr_e {UserCopyMgr=0};
  - a copy_state_e typedef for the FSM states.
- OBI req/rsp struct typedefs come from the shared OBI typedef macros; the top-level wrapper packs the flat ports into them.
- No sub-module: FSM plus datapath fit in one module. The register-interface front end is a separate wrapper, outside this block.

Test Plan:
- len=3, src=0x2000_0100, dst=0x2001_0200, zero-wait memory model:
  - reads at 0x100/0x104/0x108 are each followed by a write to 0x200/0x204/0x208 with matching data;
  - done pulse at cycle 14 after start; words_done=3; error=0.
- Grant backpressure, gnt delayed 3 cycles on every request:
  - addr/we/wdata remain stable while waiting;
  - copy completes correctly; busy is high throughout.
- len=0: done pulses 2 cycles after start; obi_req_o never asserted; words_done=0.
- obi_err_i=1 on the 2nd read response (len=4):
  - error_o=1, words_done=1, done pulses;
  - no further requests are issued.
- rst_i asserted while in WR_REQ:
  - next cycle req=0, state IDLE, all outputs 0;
  - a late rvalid is ignored;
  - a new start with len=1 then completes normally.
- Unaligned src=0x...03, dst=0x...06, plus start_i pulsed again mid-copy:
  - issued addresses are 0x...00 and 0x...04;
  - the second start is ignored.

Source files
------------

// File: rtl/user_obi_copy_mgr_pkg.sv
// user_obi_copy_mgr_pkg: manager enumeration and copy FSM state type for the user domain
package user_obi_copy_mgr_pkg;
  localparam int unsigned NumUserDomainManagers = 1;
  typedef enum logic [0:0] {UserCopyMgr = 1'b0} user_mgr_e;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} copy_state_e;
  localparam logic [3:0] FullBe = 4'hF;
endpackage

// File: rtl/user_obi_copy_mgr.sv
// user_obi_copy_mgr: OBI manager copying a block of words from src to dst, one read then one write per word
module user_obi_copy_mgr
  import user_obi_copy_mgr_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [LenWidth-1:0]  words_done_o,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i
);
  localparam logic [AddrWidth-1:0] Step = AddrWidth'(4);
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);
  copy_state_e state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0] rem_q, rem_d, cnt_q, cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic err_q, err_d;
  logic rd_req, wr_req;
  always_comb begin
    rd_req = state_q == RD_REQ;
    wr_req = state_q == WR_REQ;
    obi_req_o = rd_req | wr_req;
    obi_we_o = wr_req;
    obi_be_o = obi_req_o ? FullBe : 4'h0;
    obi_addr_o = wr_req ? dst_q : rd_req ? src_q : '0;
    obi_wdata_o = wr_req ? data_q : '0;
    busy_o = state_q != IDLE;
    done_o = state_q == FIN;
    error_o = err_q;
    words_done_o = cnt_q;
  end
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        err_d = 1'b0;
        cnt_d = '0;
        src_d = src_addr_i & WordMask;
        dst_d = dst_addr_i & WordMask;
        rem_d = len_i;
        state_d = len_i == '0 ? FIN : RD_REQ;
      end
      RD_REQ: state_d = obi_gnt_i ? RD_WAIT : RD_REQ;
      RD_WAIT: if (obi_rvalid_i) begin
        data_d = obi_err_i ? data_q : obi_rdata_i;
        err_d = obi_err_i;
        state_d = obi_err_i ? FIN : WR_REQ;
      end
      WR_REQ: state_d = obi_gnt_i ? WR_WAIT : WR_REQ;
      WR_WAIT: if (obi_rvalid_i) begin
        if (obi_err_i) begin
          err_d = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + LenWidth'(1);
          src_d = src_q + Step;
          dst_d = dst_q + Step;
          rem_d = rem_q - LenWidth'(1);
          state_d = rem_q == LenWidth'(1) ? FIN : RD_REQ;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// tb_user_obi_copy_mgr: scoreboarded directed bench with a responding OBI memory model
module tb_user_obi_copy_mgr;
  logic clk, rst_i, start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic busy_o, done_o, error_o;
  logic [15:0] words_done_o;
  logic obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0] obi_be_o;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t exp_q[$];
  int errors = 0, checks = 0;
  int rd_dly = 0, wr_dly = 0, rd_cnt = 0, err_at = 0, late_req = 0, late_done = 0;
  user_obi_copy_mgr dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .words_done_o(words_done_o), .obi_req_o(obi_req_o),
    .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push_read(input logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask
  task automatic push_words(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      push_read((s & ~32'h3) + 32'(4 * i));
      exp_q.push_back('{we: 1'b1, addr: (d & ~32'h3) + 32'(4 * i), data: mem((s & ~32'h3) + 32'(4 * i))});
    end
  endtask
  initial begin
    bit pend, pend_err;
    logic [31:0] pend_data, h_addr, h_wdata;
    logic h_we;
    int waitc;
    txn_t e;
    pend = 0; pend_err = 0; pend_data = 0; waitc = 0;
    h_addr = 0; h_wdata = 0; h_we = 0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
    forever begin
      @(negedge clk);
      obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
      if (rst_i) begin
        exp_q.delete();
        pend = 0;
        waitc = 0;
      end else begin
        if (pend) begin
          obi_rvalid_i = 1; obi_rdata_i = pend_data; obi_err_i = pend_err; pend = 0;
        end
        if (late_req != late_done) begin
          obi_rvalid_i = 1; obi_rdata_i = 32'hDEAD_BEEF; late_done = late_req;
        end
        if (obi_req_o) begin
          if (waitc > 0) begin
            chk("hold_addr", obi_addr_o, h_addr);
            chk("hold_we", obi_we_o, h_we);
            chk("hold_wdata", obi_wdata_o, h_wdata);
          end else begin
            h_addr = obi_addr_o; h_we = obi_we_o; h_wdata = obi_wdata_o;
          end
          if (waitc >= (obi_we_o ? wr_dly : rd_dly)) begin
            obi_gnt_i = 1;
            waitc = 0;
            chk("req_be", obi_be_o, 4'hF);
            if (exp_q.size() == 0) chk("unexpected_req", obi_addr_o, 32'hFFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              chk("txn_we", obi_we_o, e.we);
              chk("txn_addr", obi_addr_o, e.addr);
              if (e.we) chk("txn_wdata", obi_wdata_o, e.data);
            end
            pend = 1;
            pend_data = obi_we_o ? 32'h0 : mem(obi_addr_o);
            pend_err = 0;
            if (!obi_we_o) begin
              rd_cnt++;
              pend_err = rd_cnt == err_at;
            end
          end else waitc++;
        end else waitc = 0;
      end
    end
  end
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int exp_words, input logic exp_err, input int exp_lat, input bit restart);
    bit busy_ok, req_seen, got;
    int cyc;
    busy_ok = 1; req_seen = 0; got = 0;
    src_addr_i = s; dst_addr_i = d; len_i = n; start_i = 1; cyc = 1;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start_i = restart && cyc == 4;
      if (start_i) begin
        src_addr_i = 32'h5000_0000; dst_addr_i = 32'h6000_0000; len_i = 16'd9;
      end
      if (cyc == 2) begin
        chk("start_clr_err", error_o, 0);
        chk("start_clr_words", words_done_o, 0);
      end
      if (!busy_o) busy_ok = 0;
      if (obi_req_o) req_seen = 1;
      got = done_o;
    end
    chk("done_seen", got, 1);
    if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
    chk("busy_throughout", busy_ok, 1);
    chk("words_done", words_done_o, exp_words);
    chk("error", error_o, exp_err);
    if (n == 0) chk("len0_no_req", req_seen, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_o, 0);
    chk("busy_drop", busy_o, 0);
    chk("error_sticky", error_o, exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask
  initial begin
    bit ok;
    rst_i = 1; start_i = 0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_words", words_done_o, 0);
    chk("rst_req", obi_req_o, 0);
    chk("rst_addr", obi_addr_o, 0);
    chk("rst_be", obi_be_o, 0);
    rst_i = 0;
    @(posedge clk); #1;
    push_words(32'h2000_0100, 32'h2001_0200, 3);
    run(32'h2000_0100, 32'h2001_0200, 16'd3, 3, 1'b0, 14, 1'b0);
    rd_dly = 3; wr_dly = 3;
    push_words(32'h2000_0300, 32'h2001_0300, 2);
    run(32'h2000_0300, 32'h2001_0300, 16'd2, 2, 1'b0, 0, 1'b0);
    rd_dly = 0; wr_dly = 0;
    run(32'h2000_0000, 32'h2001_0000, 16'd0, 0, 1'b0, 2, 1'b0);
    err_at = rd_cnt + 2;
    push_words(32'h2000_0400, 32'h2001_0400, 1);
    push_read(32'h2000_0404);
    run(32'h2000_0400, 32'h2001_0400, 16'd4, 1, 1'b1, 0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_req_after_err", obi_req_o, 0);
    end
    push_words(32'hFFFF_FFFC, 32'h1000_0000, 2);
    run(32'hFFFF_FFFC, 32'h1000_0000, 16'd2, 2, 1'b0, 10, 1'b0);
    push_words(32'h3000_0003, 32'h3000_1006, 2);
    run(32'h3000_0003, 32'h3000_1006, 16'd2, 2, 1'b0, 10, 1'b1);
    push_words(32'h2000_0600, 32'h2001_0600, 2);
    src_addr_i = 32'h2000_0600; dst_addr_i = 32'h2001_0600; len_i = 16'd2; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = words_done_o == 16'd1;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("first_word_done", ok, 1);
    wr_dly = 1000;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = obi_req_o && obi_we_o;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("reach_wr_req", ok, 1);
    rst_i = 1;
    @(posedge clk); #1;
    chk("midrst_req", obi_req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_words", words_done_o, 0);
    chk("midrst_addr", obi_addr_o, 0);
    chk("midrst_we", obi_we_o, 0);
    rst_i = 0; wr_dly = 0;
    late_req++;
    ok = 1;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy_o || done_o || obi_req_o || error_o || words_done_o != 0) ok = 0;
    end
    chk("late_rvalid_ignored", ok, 1);
    push_words(32'h2000_0800, 32'h2001_0800, 1);
    run(32'h2000_0800, 32'h2001_0800, 16'd1, 1, 1'b0, 6, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
